// File: rtl/pattern_det.sv
// Serial pattern detector with run-time pattern, length and overlap mode.
// Optional saturating match counter enabled by defining MATCH_COUNT_EN.
module pattern_det #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               data_valid,
  input  logic               data_in,
`ifdef MATCH_COUNT_EN
  input  logic               count_clr,
  output logic [COUNT_W-1:0] match_count,
`endif
  output logic               match
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  generate
    if (MAX_LEN < 2 || MAX_LEN > 32 || COUNT_W < 1) begin : g_param_err
      $error("pattern_det: unsupported parameter set");
    end
  endgenerate

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match;

  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_shift;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;

  always_comb begin
    w_len_clamped = cfg_len;
    if (cfg_len == '0)
      w_len_clamped = LEN_W'(1);
    else if (cfg_len > LEN_MAX)
      w_len_clamped = LEN_MAX;
  end

  // cfg_load owns the edge, so a simultaneous valid bit is dropped
  assign w_shift    = data_valid & ~cfg_load;
  assign w_hist_nxt = w_shift ? {r_hist[MAX_LEN-2:0], data_in} : r_hist;
  assign w_fill_nxt = !w_shift           ? r_fill :
                      (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign w_mask[i] = (i < int'(r_len));
  end

  assign w_hit = w_shift && (w_fill_nxt >= r_len) &&
                 (((w_hist_nxt ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pat   <= '0;
      r_len   <= LEN_MAX;
      r_ovl   <= 1'b1;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (cfg_load) begin
      r_pat   <= cfg_pattern;
      r_len   <= w_len_clamped;
      r_ovl   <= cfg_overlap;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_hist  <= w_hist_nxt;
      // non-overlap: restart the fill so the next match needs len fresh bits
      r_fill  <= (w_hit && !r_ovl) ? '0 : w_fill_nxt;
      r_match <= w_hit;
    end
  end

  assign match = r_match;

`ifdef MATCH_COUNT_EN
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_count <= '0;
    else if (count_clr)
      r_count <= w_hit ? COUNT_W'(1) : '0;
    else if (w_hit && r_count != CNT_MAX)
      r_count <= r_count + COUNT_W'(1);
  end

  assign match_count = r_count;
`endif

endmodule

// File: tb/tb_pattern_det.sv
// Bench for pattern_det: directed plan cases plus random traffic against a
// queue-based model of the received bit stream.
module tb_pattern_det;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
`ifdef MATCH_COUNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               data_valid = 1'b0;
  logic               data_in = 1'b0;
  logic               match;
`ifdef MATCH_COUNT_EN
  logic               count_clr = 1'b0;
  logic [CW-1:0]      match_count;
`endif

  pattern_det #(.MAX_LEN(MAX_LEN), .COUNT_W(CW)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .data_valid  (data_valid),
    .data_in     (data_in),
`ifdef MATCH_COUNT_EN
    .count_clr   (count_clr),
    .match_count (match_count),
`endif
    .match       (match)
  );

  always #5 clock = ~clock;

  // reference model: bits received since the last flush, newest at the back
  bit         mq[$];
  bit [7:0]   m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_exp;
  int         m_cnt;
  int         n_chk = 0;
  int         n_err = 0;
  int         n_pulse = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hit();
    if (mq.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (mq[mq.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pat = '0; m_len = MAX_LEN; m_ovl = 1'b1; m_exp = 1'b0; m_cnt = 0;
  endtask

  task automatic cyc();
    bit hit;
    @(posedge clock);
    hit = 1'b0;
    if (cfg_load) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : (int'(cfg_len) > MAX_LEN ? MAX_LEN : int'(cfg_len));
      m_ovl = cfg_overlap;
      mq.delete();
    end else if (data_valid) begin
      mq.push_back(data_in);
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
      hit = model_hit();
      if (hit && !m_ovl) mq.delete();
    end
    m_exp = hit;
`ifdef MATCH_COUNT_EN
    if (count_clr) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
    #1;
    check("match", match, m_exp);
`ifdef MATCH_COUNT_EN
    check("count", match_count, m_cnt);
`endif
    if (match === 1'b1) n_pulse++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    model_reset();
    check("rst_match", match, 0);
`ifdef MATCH_COUNT_EN
    check("rst_count", match_count, 0);
`endif
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic load(input logic [7:0] pat, input int len, input bit ovl);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    data_valid = 1'b1; data_in = $urandom_range(0, 1);
    cyc();
    cfg_load = 1'b0; data_valid = 1'b0;
  endtask

  task automatic send(input bit b, input bit v);
    data_valid = v; data_in = b;
    cyc();
    data_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], 1'b1);
      if (gaps) send($urandom_range(0, 1), 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #2;
    check("por_match", match, 0);
    do_reset();

    // default config after reset: all-zero pattern of MAX_LEN bits
    n_pulse = 0; send_bits(32'h0, 9, 1'b0);
    check("dflt_pulses", n_pulse, 2);

    load(8'b1011, 4, 1'b1);
    n_pulse = 0; send_bits(32'b1011011, 7, 1'b0);
    check("ovl_pulses", n_pulse, 2);

    load(8'b1011, 4, 1'b0);
    n_pulse = 0; send_bits(32'b10110111011, 11, 1'b0);
    check("novl_pulses", n_pulse, 2);

    load(8'hA5, 8, 1'b1);
    n_pulse = 0; send_bits(32'hA5, 8, 1'b1);
    check("gap_pulses", n_pulse, 1);

    load(8'b111, 3, 1'b1);
    n_pulse = 0; send_bits(32'h3FF, 10, 1'b0);
    check("run_pulses", n_pulse, 8);

    load(8'h01, 0, 1'b1);
    n_pulse = 0; send_bits(32'b1011, 4, 1'b0);
    check("len0_pulses", n_pulse, 3);

    load(8'hA5, 15, 1'b1);
    n_pulse = 0; send_bits(32'h1A5, 9, 1'b0);
    check("len15_pulses", n_pulse, 1);

    load(8'b1011, 4, 1'b1);
    n_pulse = 0; send_bits(32'b101, 3, 1'b0);
    do_reset();
    load(8'b1011, 4, 1'b1);
    send_bits(32'b1, 1, 1'b0);
    check("rst_mid_pulses", n_pulse, 0);
    send_bits(32'b1011, 4, 1'b0);
    check("resend_pulses", n_pulse, 1);

`ifdef MATCH_COUNT_EN
    do_reset();
    load(8'h01, 1, 1'b1);
    send_bits(32'h1F, 5, 1'b0);
    check("cnt_sat", match_count, 3);
    count_clr = 1'b1;
    send(1'b1, 1'b1);
    count_clr = 1'b0;
    check("cnt_clr_hit", match_count, 1);
`endif

    // random traffic with occasional reconfiguration
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        load($urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
             $urandom_range(0, 1));
      end else begin
`ifdef MATCH_COUNT_EN
        count_clr = ($urandom_range(0, 99) < 4);
`endif
        send($urandom_range(0, 1), $urandom_range(0, 99) < 75);
`ifdef MATCH_COUNT_EN
        count_clr = 1'b0;
`endif
      end
      if (i == 700) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pattern_det.md
Name: pattern_det

Overview:
- Parametrised serial pattern detector; successor to the team's fixed 4-bit sequence detector.
- Pattern, length and overlap mode are run-time programmable. The input stream is qualified by a valid strobe.
- Sits behind a serial/deserialiser front end and flags a registered one-cycle match pulse to downstream control logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1), width of the length field. Derived; do not override.
- COUNT_W, 8, width of the match counter (optional feature only).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- cfg_load  in  1  when high, latch cfg_pattern/cfg_len/cfg_overlap and flush history.
- cfg_pattern  in  MAX_LEN  pattern. Bit [len-1] is the first bit received; bit 0 is the last.
- cfg_len  in  LEN_W  pattern length in bits.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- data_valid  in  1  data_in qualifier.
- data_in  in  1  serial data.
- match  out  1  registered one-cycle pulse on pattern detection.
- match_count  out  COUNT_W  saturating match counter (only with MATCH_COUNT_EN).
- count_clr  in  1  synchronous clear of match_count (only with MATCH_COUNT_EN).

Behaviour:
- Reset (async, resetn low):
  - pat_q = 0, len_q = MAX_LEN, ovl_q = 1.
  - hist = 0, fill = 0.
  - match = 0, match_count = 0.
- Config:
  - On a clock edge with cfg_load=1: pat_q <= cfg_pattern, len_q <= clamp(cfg_len), ovl_q <= cfg_overlap.
  - clamp: 0 -> 1; values > MAX_LEN -> MAX_LEN.
  - The same edge clears hist and fill and drives match <= 0.
  - data_valid on that edge is ignored (cfg_load has priority).
- Shift:
  - On data_valid=1 (cfg_load=0): hist <= {hist[MAX_LEN-2:0], data_in}.
  - fill <= min(fill+1, MAX_LEN).
  - data_valid=0: hist and fill hold; match <= 0.
- Detect, evaluated on the next-state values:
  - hit = data_valid & (fill_next >= len_q) & (hist_next[len_q-1:0] == pat_q[len_q-1:0]).
  - Bits above len_q-1 are masked out of the comparison.
- Output: match <= hit. Match is high the cycle after the edge that sampled the final pattern bit (latency 1). Back-to-back valid hits give consecutive high cycles.
- Overlap mode:
  - ovl_q=1: history is untouched on a hit, so a suffix of a match may start the next match.
  - ovl_q=0: a hit sets fill <= 0 on the same edge; hist is still shifted. A new match needs len_q fresh bits.
- Internal state: "filling" while fill < len_q, "armed" while fill >= len_q. No explicit FSM encoding is required beyond fill.
- Boundaries:
  - fill saturates at MAX_LEN and never wraps.
  - len_q=1 matches on every valid bit equal to pat_q[0].
  - cfg_len change without cfg_load has no effect.
- Reset mid-stream: all history is discarded; the first match after reset needs len_q valid bits.

Optional Feature:
- Macro: MATCH_COUNT_EN.
- Defined:
  - match_count increments by 1 on each edge where hit=1, saturating at 2^COUNT_W-1.
  - count_clr=1 clears it; count_clr together with hit on the same edge gives match_count = 1.
  - cfg_load does not clear the counter.
- Not defined: match_count and count_clr ports are absent; no counter logic.

Test Plan:
- Pattern 4'b1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 -> match high after bits 4 and 7 (2 pulses).
- Same config with overlap=0; stream 1,0,1,1,0,1,1,1,0,1,1 -> match after bits 4 and 11 only; bit-7 candidate suppressed.
- Pattern 8'hA5, len 8; stream 0xA5 with data_valid low every other cycle -> single match one cycle after the 8th valid bit; no match during gaps.
- len 3, pattern 3'b111; stream of ten 1s with overlap=1 -> 8 consecutive match cycles. cfg_len=0 -> behaves as len 1; cfg_len=15 (MAX_LEN=8) -> behaves as len 8.
- Assert resetn low after 3 of 4 pattern bits, release, send last bit only -> no match. Full pattern resent -> match.
- MATCH_COUNT_EN, COUNT_W=2: 5 matches -> count 3 (saturated). count_clr coincident with a hit -> count 1.
